mult_fu_slot: RTL and testbench

Pipelined integer multiply functional unit. It sits on the consumer side of the issue-stage multiply FIFO: it drives that FIFO's per-slot read enable, takes one `ISSUE_FU_PACKET` per cycle, and computes MUL/MULH/MULHSU/MULHU over `STAGES` pipeline cycles. Results are held in an output register until the complete stage grants them, and the whole pipeline back-pressures the FIFO while a result is waiting.

---
 rtl/mult_fu_slot.sv | 105 ++++++++++
 tb/tb_mult_fu_slot.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_fu_slot.sv
// mult_fu_slot: pipelined MUL/MULH/MULHSU/MULHU unit; `MULT_SQUASH_EN enables the squash flush
package mult_fu_pkg;
  localparam int XLEN = 32;
  localparam int PR_W = 6;
  localparam int ROB_W = 5;
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic [2:0]       func3;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
  } ISSUE_FU_PACKET;
  typedef struct packed {
    logic             valid;
    logic [PR_W-1:0]  dest_pr;
    logic [ROB_W-1:0] rob_entry;
    logic [XLEN-1:0]  dest_value;
  } FU_COMPLETE_PACKET;
endpackage

module mult_fu_slot #(
  parameter int STAGES = 4,
  parameter int XLEN = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  mult_fu_pkg::ISSUE_FU_PACKET    is_fu_packet,
  output logic                           fu_ready,
  input  logic                           squash,
  input  logic                           complete_grant,
  output mult_fu_pkg::FU_COMPLETE_PACKET fu_out
);
  localparam int C = 64 / STAGES;
  typedef struct packed {
    logic                          valid;
    logic [1:0]                    op;
    logic [mult_fu_pkg::PR_W-1:0]  dest_pr;
    logic [mult_fu_pkg::ROB_W-1:0] rob_entry;
    logic [63:0]                   mcand;
    logic [63:0]                   mplier;
    logic [63:0]                   partial;
  } stage_t;
  stage_t                        r_st [STAGES];
  stage_t                        w_in [STAGES];
  logic [63:0]                   w_sum [STAGES];
  mult_fu_pkg::FU_COMPLETE_PACKET r_out;
  mult_fu_pkg::FU_COMPLETE_PACKET w_out;
  logic                          w_adv;
  logic                          w_unused;
  logic [1:0]                    w_op;
  logic [63:0]                   w_rs1x;
  logic [63:0]                   w_rs2x;
  logic [XLEN-1:0]               w_res;

  assign w_op = is_fu_packet.func3[1:0];
  assign w_rs1x = {{(64-XLEN){w_op != 2'b11 && is_fu_packet.rs1_value[XLEN-1]}}, is_fu_packet.rs1_value};
  assign w_rs2x = {{(64-XLEN){!w_op[1] && is_fu_packet.rs2_value[XLEN-1]}}, is_fu_packet.rs2_value};
  assign w_adv = !r_out.valid || complete_grant;
`ifdef MULT_SQUASH_EN
  assign fu_ready = w_adv && !squash;
  assign w_unused = is_fu_packet.func3[2];
`else
  assign fu_ready = w_adv;
  assign w_unused = ^{is_fu_packet.func3[2], squash};
`endif

  // stage g adds the g-th multiplier chunk, weighted by its bit position, into the running sum
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_in[g] = '{valid: is_fu_packet.valid, op: w_op, dest_pr: is_fu_packet.dest_pr,
                         rob_entry: is_fu_packet.rob_entry, mcand: w_rs1x, mplier: w_rs2x, partial: 64'd0};
    end else begin : g_body
      assign w_in[g] = r_st[g-1];
    end
    assign w_sum[g] = w_in[g].partial + ((w_in[g].mcand * 64'(w_in[g].mplier[g*C +: C])) << (g*C));
  end

  assign w_res = r_st[STAGES-1].op == 2'b00 ? r_st[STAGES-1].partial[XLEN-1:0]
                                            : r_st[STAGES-1].partial[2*XLEN-1:XLEN];
  assign w_out = '{valid: 1'b1, dest_pr: r_st[STAGES-1].dest_pr,
                   rob_entry: r_st[STAGES-1].rob_entry, dest_value: w_res};
  assign fu_out = r_out;

  // whole pipeline plus output register moves together only when the output slot can take a result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) r_st[i] <= '0;
      r_out <= '0;
    end
`ifdef MULT_SQUASH_EN
    else if (squash) begin
      for (int i = 0; i < STAGES; i++) r_st[i].valid <= 1'b0;
      r_out.valid <= 1'b0;
    end
`endif
    else if (w_adv) begin
      for (int i = 0; i < STAGES; i++) begin
        r_st[i] <= w_in[i];
        r_st[i].partial <= w_sum[i];
      end
      r_out <= r_st[STAGES-1].valid ? w_out : '0;
    end
  end
endmodule

// File: tb/tb_mult_fu_slot.sv
// tb_mult_fu_slot: randomized bench for mult_fu_slot against a latency/arithmetic reference model
module tb_mult_fu_slot;
  import mult_fu_pkg::*;
  localparam int ST = 4;
`ifdef MULT_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif
  localparam ISSUE_FU_PACKET BUB = '0;

  logic              clock;
  logic              reset;
  ISSUE_FU_PACKET    is_fu_packet;
  logic              fu_ready;
  logic              squash;
  logic              complete_grant;
  FU_COMPLETE_PACKET fu_out;

  int                errors = 0;
  int                checks = 0;
  FU_COMPLETE_PACKET m_pipe [ST];
  FU_COMPLETE_PACKET m_out;
  logic              m_ready;
  logic              m_acc;
  logic              ready_seen;

  mult_fu_slot #(.STAGES(ST), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .is_fu_packet(is_fu_packet), .fu_ready(fu_ready),
    .squash(squash), .complete_grant(complete_grant), .fu_out(fu_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_val(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p = (op == 2'b11) ? ua * ub : (op == 2'b10) ? sa * ub : sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic ISSUE_FU_PACKET mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [PR_W-1:0] pr, input logic [ROB_W-1:0] rob);
    ISSUE_FU_PACKET p;
    p = '0;
    p.valid = 1'b1;
    p.rs1_value = a;
    p.rs2_value = b;
    p.func3 = {1'b0, op};
    p.dest_pr = pr;
    p.rob_entry = rob;
    return p;
  endfunction

  function automatic ISSUE_FU_PACKET rnd();
    return mk(2'($urandom_range(0, 3)), $urandom, $urandom, PR_W'($urandom), ROB_W'($urandom));
  endfunction

  function automatic FU_COMPLETE_PACKET expect_of(input ISSUE_FU_PACKET p);
    FU_COMPLETE_PACKET e;
    e.valid = 1'b1;
    e.dest_pr = p.dest_pr;
    e.rob_entry = p.rob_entry;
    e.dest_value = ref_val(p.func3[1:0], p.rs1_value, p.rs2_value);
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ST; i++) m_pipe[i] = '0;
    m_out = '0;
  endfunction

  // Drive one cycle of inputs, sample fu_ready mid-cycle, advance the reference model at the edge
  task automatic apply(input ISSUE_FU_PACKET p, input logic g, input logic s);
    is_fu_packet = p;
    complete_grant = g;
    squash = s;
    @(negedge clock);
    ready_seen = fu_ready;
    m_ready = (!m_out.valid || g) && !(SQ && s);
    m_acc = m_ready && p.valid;
    @(posedge clock);
    if (SQ && s) begin
      for (int i = 0; i < ST; i++) m_pipe[i].valid = 1'b0;
      m_out.valid = 1'b0;
    end else if (!m_out.valid || g) begin
      m_out = m_pipe[ST-1];
      for (int i = ST - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = p.valid ? expect_of(p) : '0;
    end
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    is_fu_packet = BUB;
    squash = 1'b0;
    complete_grant = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks += 2;
    if (fu_out !== '0) begin errors++; $display("FAIL reset_fu_out got %h want 0", fu_out); end
    if (fu_ready !== 1'b1) begin errors++; $display("FAIL reset_fu_ready got %b want 1", fu_ready); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    checks++;
    if (fu_ready !== 1'b1) begin errors++; $display("FAIL release_fu_ready got %b want 1", fu_ready); end
  endtask

  task automatic test_mul_basic;
    apply(mk(2'b00, 32'hFFFFFFFE, 32'd3, 6'd9, 5'd4), 1'b0, 1'b0);
    for (int i = 1; i <= ST + 1; i++) begin
      apply(BUB, i == ST + 1, 1'b0);
      checks += 2;
      if (ready_seen !== m_ready) begin errors++; $display("FAIL mul_ready got %b want %b", ready_seen, m_ready); end
      if (fu_out.valid !== m_out.valid || (m_out.valid && fu_out !== m_out)) begin
        errors++; $display("FAIL mul_out got %h want %h", fu_out, m_out);
      end
      if (i == ST) begin
        checks++;
        if (fu_out.valid !== 1'b1 || fu_out.dest_value !== 32'hFFFFFFFA || fu_out.dest_pr !== 6'd9 || fu_out.rob_entry !== 5'd4) begin
          errors++; $display("FAIL mul_latency got %h want valid dest_value fffffffa pr 9 rob 4", fu_out);
        end
      end else if (i < ST) begin
        checks++;
        if (fu_out.valid !== 1'b0) begin errors++; $display("FAIL mul_early got valid %b want 0", fu_out.valid); end
      end
    end
  endtask

  task automatic test_high_variants;
    logic [31:0] want [3];
    int k;
    want[0] = 32'h00000000;
    want[1] = 32'h80000000;
    want[2] = 32'h7FFFFFFF;
    k = 0;
    for (int c = 0; c < ST + 6; c++) begin
      apply(c < 3 ? mk(2'(c + 1), 32'h80000000, 32'hFFFFFFFF, 6'(c), 5'(c)) : BUB, 1'b1, 1'b0);
      checks += 2;
      if (ready_seen !== m_ready) begin errors++; $display("FAIL high_ready got %b want %b", ready_seen, m_ready); end
      if (fu_out.valid !== m_out.valid || (m_out.valid && fu_out !== m_out)) begin
        errors++; $display("FAIL high_out got %h want %h", fu_out, m_out);
      end
      if (fu_out.valid === 1'b1 && k < 3) begin
        checks++;
        if (fu_out.dest_value !== want[k]) begin
          errors++; $display("FAIL high_value op %0d got %h want %h", k + 1, fu_out.dest_value, want[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 3) begin errors++; $display("FAIL high_count got %0d want 3", k); end
  endtask

  task automatic test_backpressure;
    ISSUE_FU_PACKET ops [6];
    int idx, got, stalled;
    idx = 0;
    got = 0;
    stalled = 0;
    for (int i = 0; i < 6; i++) begin
      ops[i] = rnd();
      ops[i].rob_entry = 5'(i + 10);
    end
    for (int c = 0; c < 10; c++) begin
      apply(idx < 6 ? ops[idx] : BUB, 1'b0, 1'b0);
      if (m_acc) idx++;
      if (ready_seen === 1'b0) stalled++;
      checks += 2;
      if (ready_seen !== m_ready) begin errors++; $display("FAIL bp_ready got %b want %b", ready_seen, m_ready); end
      if (fu_out.valid !== m_out.valid || (m_out.valid && fu_out !== m_out)) begin
        errors++; $display("FAIL bp_out got %h want %h", fu_out, m_out);
      end
    end
    checks++;
    if (stalled != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d want 5", stalled); end
    for (int c = 0; c < 12; c++) begin
      if (got < 6) begin
        checks++;
        if (fu_out.valid !== 1'b1 || fu_out.rob_entry !== ops[got].rob_entry) begin
          errors++; $display("FAIL bp_order slot %0d got %h want rob %0d", got, fu_out, ops[got].rob_entry);
        end
        got++;
      end
      apply(idx < 6 ? ops[idx] : BUB, 1'b1, 1'b0);
      if (m_acc) idx++;
      checks += 2;
      if (ready_seen !== m_ready) begin errors++; $display("FAIL bp_drain_ready got %b want %b", ready_seen, m_ready); end
      if (fu_out.valid !== m_out.valid || (m_out.valid && fu_out !== m_out)) begin
        errors++; $display("FAIL bp_drain_out got %h want %h", fu_out, m_out);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 20 + ST + 2; c++) begin
      apply(c < 20 ? rnd() : BUB, 1'b1, 1'b0);
      checks += 3;
      if (ready_seen !== 1'b1) begin errors++; $display("FAIL b2b_ready_drop cycle %0d got %b want 1", c, ready_seen); end
      if (ready_seen !== m_ready) begin errors++; $display("FAIL b2b_ready got %b want %b", ready_seen, m_ready); end
      if (fu_out.valid !== m_out.valid || (m_out.valid && fu_out !== m_out)) begin
        errors++; $display("FAIL b2b_out got %h want %h", fu_out, m_out);
      end
    end
  endtask

  task automatic test_squash;
    int seen;
    seen = 0;
    for (int c = 0; c < 5; c++) apply(c < 4 ? rnd() : BUB, 1'b0, 1'b0);
    checks++;
    if (fu_out.valid !== 1'b1) begin errors++; $display("FAIL sq_setup got valid %b want 1", fu_out.valid); end
    apply(rnd(), 1'b1, 1'b1);
    checks += 2;
    if (ready_seen !== m_ready) begin errors++; $display("FAIL sq_ready got %b want %b", ready_seen, m_ready); end
    if (fu_out.valid !== m_out.valid || (m_out.valid && fu_out !== m_out)) begin
      errors++; $display("FAIL sq_out got %h want %h", fu_out, m_out);
    end
    if (fu_out.valid === 1'b1) seen++;
    for (int c = 0; c < 10; c++) begin
      apply(BUB, 1'b1, 1'b0);
      if (fu_out.valid === 1'b1) seen++;
      checks += 2;
      if (ready_seen !== m_ready) begin errors++; $display("FAIL sq_after_ready got %b want %b", ready_seen, m_ready); end
      if (fu_out.valid !== m_out.valid || (m_out.valid && fu_out !== m_out)) begin
        errors++; $display("FAIL sq_after_out got %h want %h", fu_out, m_out);
      end
    end
    checks++;
    if (seen != (SQ ? 0 : 4)) begin errors++; $display("FAIL sq_result_count got %0d want %0d", seen, SQ ? 0 : 4); end
  endtask

  task automatic test_async_reset;
    for (int c = 0; c < 5; c++) apply(c < 4 ? rnd() : BUB, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks += 2;
    if (fu_out.valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", fu_out.valid); end
    if (fu_out !== '0) begin errors++; $display("FAIL areset_fu_out got %h want 0", fu_out); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    checks++;
    if (fu_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", fu_ready); end
    for (int c = 0; c < ST + 3; c++) begin
      apply(BUB, 1'b1, 1'b0);
      checks += 2;
      if (ready_seen !== m_ready) begin errors++; $display("FAIL areset_drain_ready got %b want %b", ready_seen, m_ready); end
      if (fu_out.valid !== m_out.valid || (m_out.valid && fu_out !== m_out)) begin
        errors++; $display("FAIL areset_drain_out got %h want %h", fu_out, m_out);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mul_basic();
    test_high_variants();
    test_backpressure();
    test_back_to_back();
    test_squash();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
